// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter: one outstanding burst on the shared slave port at a time.
// Define ARB_RR_EN for round-robin arbitration; the default build gives M1 fixed priority over M0.
module axi_rd_arbiter #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4,
   parameter int SIZE_W = 3
) (
   input  logic              ACLK,
   input  logic              rst,

   input  logic [ID_W-1:0]   M0_ARID,
   input  logic [ADDR_W-1:0] M0_ARAddr,
   input  logic [LEN_W-1:0]  M0_ARLen,
   input  logic [SIZE_W-1:0] M0_ARSize,
   input  logic [1:0]        M0_ARBurst,
   input  logic              M0_ARValid,
   output logic              M0_ARReady,
   output logic [ID_W-1:0]   M0_RID,
   output logic [DATA_W-1:0] M0_RData,
   output logic [1:0]        M0_RResp,
   output logic              M0_RLast,
   output logic              M0_RValid,
   input  logic              M0_RReady,

   input  logic [ID_W-1:0]   M1_ARID,
   input  logic [ADDR_W-1:0] M1_ARAddr,
   input  logic [LEN_W-1:0]  M1_ARLen,
   input  logic [SIZE_W-1:0] M1_ARSize,
   input  logic [1:0]        M1_ARBurst,
   input  logic              M1_ARValid,
   output logic              M1_ARReady,
   output logic [ID_W-1:0]   M1_RID,
   output logic [DATA_W-1:0] M1_RData,
   output logic [1:0]        M1_RResp,
   output logic              M1_RLast,
   output logic              M1_RValid,
   input  logic              M1_RReady,

   output logic [ID_W-1:0]   S_ARID,
   output logic [ADDR_W-1:0] S_ARAddr,
   output logic [LEN_W-1:0]  S_ARLen,
   output logic [SIZE_W-1:0] S_ARSize,
   output logic [1:0]        S_ARBurst,
   output logic              S_ARValid,
   input  logic              S_ARReady,
   input  logic [ID_W-1:0]   S_RID,
   input  logic [DATA_W-1:0] S_RData,
   input  logic [1:0]        S_RResp,
   input  logic              S_RLast,
   input  logic              S_RValid,
   output logic              S_RReady,

   output logic              owner,
   output logic              busy,
   output logic              rlast_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]       state;
   logic [LEN_W-1:0] beat_cnt;
   logic [LEN_W-1:0] len_q;
   logic             any_req;
   logic             grant_m1;
   logic             ar_hs;
   logic             r_hs;
   logic             len_err;

   assign any_req = M0_ARValid | M1_ARValid;

`ifdef ARB_RR_EN
   // On a tie the master that was not granted last time wins.
   always_comb begin
      if (M0_ARValid && M1_ARValid) grant_m1 = ~owner;
      else                          grant_m1 = M1_ARValid;
   end
`else
   assign grant_m1 = M1_ARValid;
`endif

   assign ar_hs = (state == ST_ADDR) && S_ARValid && S_ARReady;
   assign r_hs  = (state == ST_DATA) && S_RValid && S_RReady;

   // A beat is wrong if RLast disagrees with the beat index implied by the latched ARLen.
   assign len_err = r_hs && (S_RLast ? (beat_cnt != len_q) : (beat_cnt == len_q));

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge ACLK) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner     <= 1'b0;
         beat_cnt  <= '0;
         len_q     <= '0;
         rlast_err <= 1'b0;
      end else begin
         rlast_err <= len_err;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  owner    <= grant_m1;
                  len_q    <= grant_m1 ? M1_ARLen : M0_ARLen;
                  beat_cnt <= '0;
                  state    <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (ar_hs) state <= ST_DATA;
            end
            ST_DATA: begin
               if (r_hs) begin
                  beat_cnt <= beat_cnt + LEN_W'(1);
                  if (S_RLast) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

   // NOTE: every output driven here gets a default first so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      S_ARID     = '0;
      S_ARAddr   = '0;
      S_ARLen    = '0;
      S_ARSize   = '0;
      S_ARBurst  = '0;
      S_ARValid  = 1'b0;
      M0_ARReady = 1'b0;
      M1_ARReady = 1'b0;
      S_RReady   = 1'b0;
      M0_RValid  = 1'b0;
      M1_RValid  = 1'b0;

      if (state == ST_ADDR) begin
         if (owner) begin
            S_ARID     = M1_ARID;
            S_ARAddr   = M1_ARAddr;
            S_ARLen    = M1_ARLen;
            S_ARSize   = M1_ARSize;
            S_ARBurst  = M1_ARBurst;
            S_ARValid  = M1_ARValid;
            M1_ARReady = S_ARReady;
         end else begin
            S_ARID     = M0_ARID;
            S_ARAddr   = M0_ARAddr;
            S_ARLen    = M0_ARLen;
            S_ARSize   = M0_ARSize;
            S_ARBurst  = M0_ARBurst;
            S_ARValid  = M0_ARValid;
            M0_ARReady = S_ARReady;
         end
      end

      if (state == ST_DATA) begin
         if (owner) begin
            M1_RValid = S_RValid;
            S_RReady  = M1_RReady;
         end else begin
            M0_RValid = S_RValid;
            S_RReady  = M0_RReady;
         end
      end
   end

   // R payload is broadcast; only RValid tells a master the beat is its own.
   assign M0_RID   = S_RID;
   assign M0_RData = S_RData;
   assign M0_RResp = S_RResp;
   assign M0_RLast = S_RLast;
   assign M1_RID   = S_RID;
   assign M1_RData = S_RData;
   assign M1_RResp = S_RResp;
   assign M1_RLast = S_RLast;

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master read-channel arbiter between the CPU-side master ports (M0 = instruction fetch, M1 = data access) and a single downstream read slave port. It serialises AR requests, locks the grant to one master until its burst completes (R handshake with RLast), and routes R beats back to the owning master only. It replaces ad-hoc cross-master read helpers: one transaction is outstanding on the shared port at any time, and the owner is decided in one place.

## Interface
Parameters:
- ID_W, 4, AXI ID width
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- LEN_W, 4, burst length width (beats = ARLen+1)
- SIZE_W, 3, burst size width

Ports:
- ACLK  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- M{0,1}_ARID / _ARAddr / _ARLen / _ARSize / _ARBurst  in  ID_W/ADDR_W/LEN_W/SIZE_W/2  master AR payload
- M{0,1}_ARValid  in  1  master AR valid
- M{0,1}_ARReady  out  1  AR ready to master
- M{0,1}_RID / _RData / _RResp / _RLast  out  ID_W/DATA_W/2/1  R payload to master (broadcast copy of S_R*)
- M{0,1}_RValid  out  1  R valid to master, gated by ownership
- M{0,1}_RReady  in  1  master R ready
- S_ARID / _ARAddr / _ARLen / _ARSize / _ARBurst  out  as above  AR payload to slave
- S_ARValid  out  1  AR valid to slave
- S_ARReady  in  1  slave AR ready
- S_RID / _RData / _RResp / _RLast / _RValid  in  as above  slave R channel
- S_RReady  out  1  R ready to slave
- owner  out  1  current/last granted master (0 = M0, 1 = M1)
- busy  out  1  high in ADDR or DATA
- rlast_err  out  1  one-cycle pulse on burst-length violation

## Operation
- States: IDLE, ADDR, DATA. Registers: state, owner, beat counter (LEN_W), latched len (LEN_W).
- IDLE: if any M*_ARValid, select a winner (see Configuration), load owner, latch winner's ARLen, clear beat counter, go to ADDR. No ARReady asserted in IDLE.
- ADDR: S_AR* = owner's AR payload, S_ARValid = owner's ARValid; owner's ARReady = S_ARReady; non-owner ARReady = 0. On S_ARValid & S_ARReady -> DATA.
- DATA: owner's RValid = S_RValid, S_RReady = owner's RReady; non-owner RValid = 0. Each R handshake increments beat counter. Handshake with S_RLast -> IDLE.
- rlast_err pulses when a handshaked beat has S_RLast=1 and counter != latched len, or S_RLast=0 and counter == latched len. On the second case the FSM stays in DATA until RLast.
- S_AR* payload and S_ARValid are 0 outside ADDR; S_RReady is 0 outside DATA.
- M*_RID/RData/RResp/RLast are a combinational copy of slave R in all states; only RValid is gated.

## Timing
- Reset values: state IDLE, owner 0, counter 0, all ARReady/RValid/S_ARValid/S_RReady 0, busy 0, rlast_err 0.
- Arbitration latency: ARValid sampled in IDLE at edge N -> S_ARValid high in cycle N+1. Minimum AR-to-AR spacing on the shared port is 1 idle cycle after final RLast.
- Masters must hold ARValid and payload stable until ARReady (AXI rule); a master dropping ARValid in ADDR leaves S_ARValid low and the FSM waits.
- Simultaneous ARValid from both in IDLE: one grant per policy; loser keeps waiting with ARReady=0.
- New ARValid during DATA is ignored until return to IDLE.
- rst asserted mid-burst: next edge returns to IDLE with all outputs at reset values; in-flight slave beats are dropped (S_RReady=0).

## Configuration
- ARB_RR_EN defined: round-robin; on simultaneous requests grant the master that is not `owner` (last granted); single requester always wins.
- ARB_RR_EN undefined: fixed priority, M1 (data) beats M0 (instruction).

## Test plan
- Single M0 read, ARLen=0, ARAddr=0x0000_0100, slave ready immediately -> S_ARValid cycle after request, one R beat routed to M0, M1_RValid stays 0, back to IDLE, rlast_err=0.
- Both ARValid same cycle, ARB_RR_EN off -> M1 granted; repeat twice -> M1 granted both times while M0 waits; with ARB_RR_EN on -> M1 then M0.
- M1 burst ARLen=3 with S_RValid toggling and M1_RReady stalled 2 cycles -> exactly 4 handshakes, S_RReady follows M1_RReady, no beat lost or duplicated.
- Slave asserts RLast on beat 2 of ARLen=3 -> rlast_err pulse 1 cycle, FSM to IDLE; RLast absent on beat 4 -> rlast_err pulse, FSM remains DATA until RLast.
- rst high during DATA beat 1 of ARLen=3 -> next cycle IDLE, busy=0, all valids/readies 0, owner=0.
- M0 ARValid arriving while M1 in DATA -> M0_ARReady=0 throughout; M0 granted in IDLE after M1's RLast, S_ARValid one cycle later.
